rvlab_clkdrp_seq: RTL and testbench
===================================

# rvlab_clkdrp_seq

Hardware sequencer that reprograms the system-clock MMCM through its Dynamic Reconfiguration Port (DRP). On `start_i` it holds the MMCM in reset, walks a table of register entries, and performs a read-modify-write for each entry: read the register, merge in the new bits under a mask, write it back. It then releases the reset and waits for `mmcm_locked_i`. It lives in the clock manager in the `clk_100mhz` domain, alongside the TL-UL DRP adapter; an external mux selects which of the two drives the DRP.

## Interface
- `NumRegs`, default 23: number of table entries processed per run (1..128).
- `TimeoutCycles`, default 1023: maximum number of cycles spent waiting for `drp_rdy_i` or for `mmcm_locked_i`.
- `clk_i` in 1: clock (`clk_100mhz`).
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: request a reconfiguration run; sampled only in Idle.
- `busy_o` out 1: a run is in progress.
- `done_o` out 1: one-cycle pulse when a run ends, successfully or not.
- `err_o` out 1: the last run timed out; held until the next accepted start.
- `tbl_idx_o` out $clog2(NumRegs): index of the current table entry.
- `tbl_adr_i` in 7: DRP address of the entry at `tbl_idx_o`; combinational from an external ROM or register file.
- `tbl_mask_i` in 16: 1 = keep the existing bit, 0 = take the bit from `tbl_data_i`.
- `tbl_data_i` in 16: new bit values.
- `drp_en_o` out 1, `drp_we_o` out 1, `drp_adr_o` out 7, `drp_di_o` out 16: DRP request.
- `drp_rdy_i` in 1, `drp_do_i` in 16: DRP response.
- `mmcm_locked_i` in 1: MMCM lock indicator; synchronised externally.
- `rst_mmcm_o` out 1: MMCM reset.

## Operation
- All outputs are registered.
- Reset values: every output 0, `tbl_idx_o` = 0, state Idle, timer 0.
- FSM states: Idle, Read, ReadWait, Write, WriteWait, Release, WaitLock.
- Idle + `start_i`:
  - next cycle: `rst_mmcm_o`=1, `busy_o`=1, `err_o`=0, idx=0, state → Read.
  - `start_i` is ignored in every other state.
- Read:
  - issue one cycle of `drp_en_o`=1, `drp_we_o`=0, `drp_adr_o`=`tbl_adr_i`.
  - latch `tbl_mask_i`/`tbl_data_i`; timer cleared; state → ReadWait.
- ReadWait:
  - on `drp_rdy_i`: merged = (`drp_do_i` & mask) | (data & ~mask); state → Write.
- Write:
  - issue one cycle of `drp_en_o`=1, `drp_we_o`=1, same address, `drp_di_o`=merged.
  - timer cleared; state → WriteWait.
- WriteWait, on `drp_rdy_i`:
  - if idx == NumRegs-1 → Release;
  - else idx+1 → Read.
- Release: `rst_mmcm_o`=0; timer cleared; state → WaitLock.
- WaitLock: on `mmcm_locked_i` → Idle with `done_o` pulse, `busy_o`=0.
- Timeout: if the timer reaches TimeoutCycles in ReadWait, WriteWait or WaitLock:
  - `err_o`=1, `done_o` pulse, `rst_mmcm_o`=0, `busy_o`=0 → Idle.
  - The MMCM is never left in reset.
- `drp_rdy_i` outside ReadWait/WriteWait is ignored.
- `drp_do_i` is sampled only in the `drp_rdy_i` cycle of ReadWait.
- `drp_en_o` is never asserted while a previous request is still outstanding.
- Reset mid-run: all outputs return to 0 asynchronously, including releasing the MMCM reset. There is no resume; software restarts the run.
- Arithmetic:
  - idx is unsigned and never wraps past NumRegs-1.
  - The timer is $clog2(TimeoutCycles+1) bits and saturates at TimeoutCycles.

## Timing
- Start accept: `start_i` high in Idle at cycle 0 → cycle 1 `busy_o`=1, `rst_mmcm_o`=1, state Read.
- DRP request: `drp_en_o` is high for exactly the one cycle after the Read or Write state.
- Per entry with DRP ready latency L (cycles from `drp_en_o` to `drp_rdy_i`): 2·(L+1)+2 cycles.
- Full run: 1 + NumRegs·(2L+4) + 1 + lock latency.
- `done_o` rises the cycle after the terminating event and is high for one cycle.
- Simultaneous timer expiry and `drp_rdy_i` / `mmcm_locked_i`: the ready/lock wins (success path).

## Structure
- `rvlab_clkdrp_pkg`:
  - `clkdrp_seq_state_e` enum (3-bit);
  - `drp_entry_t` struct {adr[6:0], mask[15:0], data[15:0]};
  - constants `DrpAdrW`=7, `DrpDataW`=16.
- Single flat module. The timeout timer is inline; no sub-module.

## Test plan
- Table NumRegs=2:
  - entries {0x08, mask 0x1000, data 0x0145} and {0x09, 0x8000, 0x0000};
  - DRP model with L=3, contents 0xFFFF;
  - expected writes: 0x1145 to 0x08, then 0x8000 to 0x09;
  - `rst_mmcm_o` high throughout; `done_o` once after lock; `err_o`=0.
- Cycle count: L=1, NumRegs=23, lock 10 cycles after Release → `done_o` at the cycle predicted by the Timing formula.
- Lock timeout:
  - `mmcm_locked_i` held 0, TimeoutCycles=15;
  - expect `err_o`=1, `done_o` pulse 15 cycles after Release, `rst_mmcm_o`=0.
- DRP hang:
  - `drp_rdy_i` never asserted on entry 1;
  - expect timeout at TimeoutCycles, no further `drp_en_o`, `rst_mmcm_o` dropped, `err_o`=1.
- `start_i` pulsed during ReadWait and WaitLock → ignored; exactly one run; a later start clears `err_o`.
- `rst_ni` asserted in WriteWait → all outputs 0 immediately; after release a new start runs from idx 0.

Source files
------------

// File: rtl/rvlab_clkdrp_pkg.sv
// rvlab_clkdrp_pkg: shared types for the MMCM DRP reconfiguration sequencer.
// Sequencer states, table entry layout, DRP bus widths and the RMW merge.
package rvlab_clkdrp_pkg;

  localparam int DrpAdrW  = 7;
  localparam int DrpDataW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StReadWait,
    StWrite,
    StWriteWait,
    StRelease,
    StWaitLock
  } clkdrp_seq_state_e;

  typedef struct packed {
    logic [DrpAdrW-1:0]  adr;
    logic [DrpDataW-1:0] mask;
    logic [DrpDataW-1:0] data;
  } drp_entry_t;

  // mask bit 1 keeps the current register bit, 0 takes the new one
  function automatic logic [DrpDataW-1:0] drp_merge(
    input logic [DrpDataW-1:0] cur,
    input drp_entry_t          ent
  );
    return (cur & ent.mask) | (ent.data & ~ent.mask);
  endfunction

endpackage

// File: rtl/rvlab_clkdrp_seq.sv
// rvlab_clkdrp_seq: walks a register table and read-modify-writes each
// entry into the MMCM over DRP while holding it in reset, then waits for lock.
module rvlab_clkdrp_seq
  import rvlab_clkdrp_pkg::*;
#(
  parameter int NumRegs       = 23,
  parameter int TimeoutCycles = 1023,
  localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1,
  localparam int TmrW = $clog2(TimeoutCycles + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [IdxW-1:0]     tbl_idx_o,
  input  logic [DrpAdrW-1:0]  tbl_adr_i,
  input  logic [DrpDataW-1:0] tbl_mask_i,
  input  logic [DrpDataW-1:0] tbl_data_i,
  output logic                drp_en_o,
  output logic                drp_we_o,
  output logic [DrpAdrW-1:0]  drp_adr_o,
  output logic [DrpDataW-1:0] drp_di_o,
  input  logic                drp_rdy_i,
  input  logic [DrpDataW-1:0] drp_do_i,
  input  logic                mmcm_locked_i,
  output logic                rst_mmcm_o
);

  clkdrp_seq_state_e   state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [TmrW-1:0]     tmr_q, tmr_d, tmr_inc;
  logic                expire;
  drp_entry_t          ent_q, ent_d;
  logic [DrpDataW-1:0] di_q, di_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rmmcm_q, rmmcm_d;
  logic                last_ent;

  // saturating wait timer; expiry means this cycle is the last one allowed
  always_comb begin
    tmr_inc = tmr_q;
    if (tmr_q != TmrW'(TimeoutCycles)) begin
      tmr_inc = tmr_q + 1'b1;
    end
    expire = (tmr_inc == TmrW'(TimeoutCycles));
  end

  assign last_ent = (idx_q == IdxW'(NumRegs - 1));

  // next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = '0;
    ent_d   = ent_q;
    di_d    = di_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rmmcm_d = rmmcm_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rmmcm_d = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        en_d       = 1'b1;
        ent_d.adr  = tbl_adr_i;
        ent_d.mask = tbl_mask_i;
        ent_d.data = tbl_data_i;
        state_d    = StReadWait;
      end
      StReadWait: begin
        tmr_d = tmr_inc;
        if (drp_rdy_i) begin
          di_d    = drp_merge(drp_do_i, ent_q);
          state_d = StWrite;
        end else if (expire) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          rmmcm_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StWrite: begin
        en_d    = 1'b1;
        we_d    = 1'b1;
        state_d = StWriteWait;
      end
      StWriteWait: begin
        tmr_d = tmr_inc;
        if (drp_rdy_i) begin
          if (last_ent) begin
            state_d = StRelease;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          rmmcm_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StRelease: begin
        rmmcm_d = 1'b0;
        state_d = StWaitLock;
      end
      StWaitLock: begin
        tmr_d = tmr_inc;
        if (mmcm_locked_i) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (expire) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        rmmcm_d = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // state and output registers; reset also releases the MMCM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tmr_q   <= '0;
      ent_q   <= '0;
      di_q    <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rmmcm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      ent_q   <= ent_d;
      di_q    <= di_d;
      en_q    <= en_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rmmcm_q <= rmmcm_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign tbl_idx_o  = idx_q;
  assign drp_en_o   = en_q;
  assign drp_we_o   = we_q;
  assign drp_adr_o  = ent_q.adr;
  assign drp_di_o   = di_q;
  assign rst_mmcm_o = rmmcm_q;

endmodule

// File: tb/tb_rvlab_clkdrp_seq.sv
// tb_rvlab_clkdrp_seq: random tables against a DRP/MMCM model and a
// table-level reference of the expected writes and run timing.
module tb_rvlab_clkdrp_seq;
  import rvlab_clkdrp_pkg::*;

  localparam int N  = 23;
  localparam int T  = 15;
  localparam int IW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [IW-1:0] tbl_idx_o;
  logic [6:0]    tbl_adr_i;
  logic [15:0]   tbl_mask_i, tbl_data_i;
  logic          drp_en_o, drp_we_o;
  logic [6:0]    drp_adr_o;
  logic [15:0]   drp_di_o;
  logic          drp_rdy_i = 1'b0;
  logic [15:0]   drp_do_i = '0;
  logic          mmcm_locked_i = 1'b0;
  logic          rst_mmcm_o;

  drp_entry_t  tbl [N];
  logic [15:0] mem [128];
  int          cyc = 0;
  int          vec_n = 0;
  int          miss_n = 0;

  int          lat, lock_dly, hang_req;
  bit          pend, pend_we;
  int          pend_cnt;
  logic [6:0]  pend_adr;
  logic [15:0] pend_di;
  int          req_n, lock_cnt, done_n, done_cyc, fall_cyc, hang_cyc;
  int          ovl_n, low_n;
  logic        rst_prev = 1'b0;
  logic [6:0]  wr_adr [$];
  logic [6:0]  rd_adr [$];
  logic [15:0] wr_dat [$];

  rvlab_clkdrp_seq #(
    .NumRegs      (N),
    .TimeoutCycles(T)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .tbl_idx_o    (tbl_idx_o),
    .tbl_adr_i    (tbl_adr_i),
    .tbl_mask_i   (tbl_mask_i),
    .tbl_data_i   (tbl_data_i),
    .drp_en_o     (drp_en_o),
    .drp_we_o     (drp_we_o),
    .drp_adr_o    (drp_adr_o),
    .drp_di_o     (drp_di_o),
    .drp_rdy_i    (drp_rdy_i),
    .drp_do_i     (drp_do_i),
    .mmcm_locked_i(mmcm_locked_i),
    .rst_mmcm_o   (rst_mmcm_o)
  );

  assign tbl_adr_i  = tbl[tbl_idx_o].adr;
  assign tbl_mask_i = tbl[tbl_idx_o].mask;
  assign tbl_data_i = tbl[tbl_idx_o].data;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vec_n++;
    if (got !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle of the DRP slave and MMCM models, evaluated mid-cycle
  task automatic step();
    @(negedge clk_i);
    drp_rdy_i = 1'b0;
    drp_do_i  = 16'($urandom);
    if (pend && pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        drp_rdy_i = 1'b1;
        pend      = 1'b0;
        if (pend_we) mem[pend_adr] = pend_di;
        else drp_do_i = mem[pend_adr];
      end
    end
    if (drp_en_o) begin
      if (pend) ovl_n++;
      if (!rst_mmcm_o) low_n++;
      pend     = 1'b1;
      pend_we  = drp_we_o;
      pend_adr = drp_adr_o;
      pend_di  = drp_di_o;
      pend_cnt = (req_n == hang_req) ? 0 : lat;
      if (req_n == hang_req) hang_cyc = cyc;
      if (drp_we_o) begin
        wr_adr.push_back(drp_adr_o);
        wr_dat.push_back(drp_di_o);
      end else begin
        rd_adr.push_back(drp_adr_o);
      end
      req_n++;
    end
    if (rst_mmcm_o) begin
      mmcm_locked_i = 1'b0;
      lock_cnt      = 0;
    end else if (rst_prev) begin
      fall_cyc = cyc;
      lock_cnt = (lock_dly < 0) ? 0 : lock_dly;
    end
    if (!rst_mmcm_o && lock_cnt > 0) begin
      lock_cnt--;
      if (lock_cnt == 0) mmcm_locked_i = 1'b1;
    end
    rst_prev = rst_mmcm_o;
    if (done_o) begin
      done_n++;
      done_cyc = cyc;
    end
  endtask

  task automatic clr_obs();
    req_n = 0; done_n = 0; pend = 1'b0; ovl_n = 0; low_n = 0;
    done_cyc = -1; fall_cyc = -1; hang_cyc = -1;
    wr_adr.delete(); wr_dat.delete(); rd_adr.delete();
  endtask

  task automatic fill(input bit rnd_mem);
    for (int i = 0; i < N; i++) begin
      tbl[i].adr  = 7'($urandom);
      tbl[i].mask = 16'($urandom);
      tbl[i].data = 16'($urandom);
    end
    for (int a = 0; a < 128; a++) mem[a] = rnd_mem ? 16'($urandom) : 16'hFFFF;
  endtask

  // l: DRP latency, ld: lock delay after Release (<0 never),
  // hq: request number that never completes (<0 none), inj: stray starts
  task automatic run(input int l, input int ld, input int hq, input bit inj);
    logic [15:0] m [128];
    logic [6:0]  ea [$];
    logic [15:0] ed [$];
    int          s, n_ent, n_req, n_rd, exp_done;
    bit          inj_rw, inj_wl, fail_exp;
    logic [15:0] v;
    lat = l; lock_dly = ld; hang_req = hq;
    inj_rw = 1'b0; inj_wl = 1'b0;
    m = mem;
    n_ent = (hq < 0) ? N : hq / 2;
    n_req = (hq < 0) ? 2 * N : hq + 1;
    n_rd  = (hq < 0) ? N : hq / 2 + 1;
    fail_exp = (ld < 0) || (hq >= 0);
    for (int i = 0; i < n_ent; i++) begin
      v = (m[tbl[i].adr] & tbl[i].mask) | (tbl[i].data & ~tbl[i].mask);
      m[tbl[i].adr] = v;
      ea.push_back(tbl[i].adr);
      ed.push_back(v);
    end
    clr_obs();
    s = cyc;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("accept", {busy_o, rst_mmcm_o, err_o}, 3'b110);
    for (int k = 0; k < 3000 && done_n == 0; k++) begin
      step();
      start_i = 1'b0;
      if (inj && done_n == 0 && !inj_rw && req_n == 1) begin
        start_i = 1'b1;
        inj_rw  = 1'b1;
      end
      if (inj && done_n == 0 && !inj_wl && fall_cyc >= 0) begin
        start_i = 1'b1;
        inj_wl  = 1'b1;
      end
    end
    start_i = 1'b0;
    chk("run_done", done_n, 1);
    chk("final", {busy_o, rst_mmcm_o, err_o}, {2'b00, fail_exp});
    repeat (4) step();
    chk("done_pulses", done_n, 1);
    chk("req_count", req_n, n_req);
    chk("wr_count", wr_adr.size(), n_ent);
    chk("rd_count", rd_adr.size(), n_rd);
    for (int i = 0; i < n_ent && i < wr_adr.size(); i++) begin
      chk($sformatf("wr[%0d]", i), {wr_adr[i], wr_dat[i]}, {ea[i], ed[i]});
    end
    for (int i = 0; i < n_rd && i < rd_adr.size(); i++) begin
      chk($sformatf("rd[%0d]", i), rd_adr[i], tbl[i].adr);
    end
    chk("overlap", ovl_n, 0);
    chk("drp_in_rst", low_n, 0);
    if (hq >= 0) begin
      chk("hang_en_cyc", hang_cyc, s + 2 * l + 6);
      exp_done = hang_cyc + T;
    end else begin
      chk("release_cyc", fall_cyc, s + 2 + N * (2 * l + 4));
      exp_done = (ld < 0) ? fall_cyc + T : s + 2 + N * (2 * l + 4) + ld;
    end
    chk("done_cyc", done_cyc, exp_done);
  endtask

  initial begin
    lat = 1; lock_dly = -1; hang_req = -1;
    clr_obs();
    fill(1'b0);
    repeat (3) step();
    chk("reset_outs",
        {busy_o, done_o, err_o, drp_en_o, drp_we_o, rst_mmcm_o,
         tbl_idx_o, drp_adr_o, drp_di_o}, '0);
    rst_ni = 1'b1;
    repeat (2) step();

    tbl[0] = '{adr: 7'h08, mask: 16'h1000, data: 16'h0145};
    tbl[1] = '{adr: 7'h09, mask: 16'h8000, data: 16'h0000};
    run(3, 4, -1, 1'b0);
    chk("dir_w0", {wr_adr[0], wr_dat[0]}, {7'h08, 16'h1145});
    chk("dir_w1", {wr_adr[1], wr_dat[1]}, {7'h09, 16'h8000});

    repeat (4) begin
      fill(1'b1);
      run(int'($urandom_range(1, 4)), int'($urandom_range(1, T)), -1, 1'b0);
    end

    fill(1'b1);
    run(1, 10, -1, 1'b0);
    fill(1'b1);
    run(2, T, -1, 1'b0);
    fill(1'b1);
    run(2, -1, -1, 1'b0);
    fill(1'b1);
    run(3, 6, -1, 1'b1);
    fill(1'b1);
    run(2, -1, 2, 1'b0);

    fill(1'b1);
    clr_obs();
    lat = 2; lock_dly = 5; hang_req = -1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 200 && req_n < 2; k++) step();
    chk("reach_ww", {req_n, drp_we_o}, {32'd2, 1'b1});
    #2 rst_ni = 1'b0;
    #1 chk("rst_async",
           {busy_o, done_o, err_o, drp_en_o, drp_we_o, rst_mmcm_o,
            tbl_idx_o, drp_adr_o, drp_di_o}, '0);
    repeat (3) step();
    rst_ni = 1'b1;
    repeat (2) step();
    run(2, 5, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
